adc_spi_sampler: RTL

//   Periodically reads a 12-bit serial ADC (AD7476-style: 4 leading zeros + 12 data bits, MSB first)

---
 rtl/adc_spi_sampler.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/adc_spi_sampler.sv
// Periodic reader for a 12-bit AD7476-style serial ADC; delivers a signed,
// sign-extended sample with a one-cycle strobe for the downstream low-pass filter.
module adc_spi_sampler #(
    parameter int WIDTH       = 16,
    parameter int ADC_BITS    = 12,
    parameter int FRAME_BITS  = 16,
    parameter int CLK_DIV     = 4,
    parameter int SAMP_PERIOD = 1000
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic             adc_sdo,
    output logic             adc_cs_n,
    output logic             adc_sclk,
    output logic [WIDTH-1:0] samp_out,
    output logic             samp_valid,
    output logic             busy,
    output logic             overrun
);

    localparam int PER_W = (SAMP_PERIOD > 1) ? $clog2(SAMP_PERIOD) : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMP_PERIOD - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        DONE
    } state_t;

    state_t                  state_q;
    logic [1:0]              sync_q;
    logic [PER_W-1:0]        per_q, per_d;
    logic                    trigger;
    logic [DIV_W-1:0]        div_q;
    logic [BIT_W-1:0]        bit_q;
    logic [FRAME_BITS-1:0]   shift_q;
    logic                    cs_n_q;
    logic                    sclk_q;
    logic [WIDTH-1:0]        samp_q, samp_d;
    logic                    valid_q;
    logic                    busy_q;
    logic                    overrun_q;
    logic [ADC_BITS-1:0]     raw;
    logic [ADC_BITS-1:0]     offs;

    // adc_sdo is asynchronous to clk; two flops before it reaches the shift register.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], adc_sdo};
        end
    end

    always_comb begin
        per_d   = per_q;
        trigger = 1'b0;
        if (en) begin
            trigger = (per_q == '0);
            per_d   = (per_q == PER_LAST) ? '0 : per_q + PER_W'(1);
        end else begin
            per_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            per_q <= '0;
        end else begin
            per_q <= per_d;
        end
    end

    // Offset-binary to two's complement: flipping the MSB subtracts 2^(ADC_BITS-1).
    assign raw    = shift_q[ADC_BITS-1:0];
    assign offs   = {~raw[ADC_BITS-1], raw[ADC_BITS-2:0]};
    assign samp_d = {{(WIDTH - ADC_BITS){offs[ADC_BITS-1]}}, offs};

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b1;
            samp_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (trigger && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (trigger) begin
                        state_q <= CS_SETUP;
                        cs_n_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        div_q   <= '0;
                        bit_q   <= '0;
                        shift_q <= '0;
                    end
                end
                CS_SETUP: begin
                    if (div_q == DIV_LAST) begin
                        div_q   <= '0;
                        sclk_q  <= 1'b0;
                        state_q <= SHIFT;
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                SHIFT: begin
                    if (div_q != DIV_LAST) begin
                        div_q <= div_q + DIV_W'(1);
                    end else begin
                        div_q <= '0;
                        // The capture coincides with the edge that drives sclk back high.
                        if (!sclk_q) begin
                            sclk_q  <= 1'b1;
                            shift_q <= {shift_q[FRAME_BITS-2:0], sync_q[1]};
                        end else if (bit_q == BIT_LAST) begin
                            state_q <= CS_HOLD;
                        end else begin
                            bit_q  <= bit_q + BIT_W'(1);
                            sclk_q <= 1'b0;
                        end
                    end
                end
                CS_HOLD: begin
                    if (div_q == DIV_LAST) begin
                        div_q   <= '0;
                        cs_n_q  <= 1'b1;
                        samp_q  <= samp_d;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign adc_cs_n   = cs_n_q;
    assign adc_sclk   = sclk_q;
    assign samp_out   = samp_q;
    assign samp_valid = valid_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;

    validNoRepeat: assert property (@(posedge clk) disable iff (!nrst) samp_valid |=> !samp_valid);
    busyMatchesState: assert property (@(posedge clk) disable iff (!nrst) busy == (state_q != IDLE));

endmodule
